// File: rtl/parser_pkg.sv
// Shared parser definitions: parse-action field layout, action type codes and the
// sub-parser FSM state encoding.
package parser_pkg;

    localparam int unsigned ACT_LEN       = 16;
    localparam int unsigned ACT_VALID_BIT = 15;
    localparam int unsigned ACT_OFF_HI    = 12;
    localparam int unsigned ACT_OFF_LO    = 6;
    localparam int unsigned ACT_ODD_BIT   = 5;
    localparam int unsigned ACT_IDX_HI    = 4;
    localparam int unsigned ACT_IDX_LO    = 2;
    localparam int unsigned ACT_TYPE_HI   = 1;
    localparam int unsigned ACT_TYPE_LO   = 0;

    localparam int unsigned OFF_W       = ACT_OFF_HI - ACT_OFF_LO + 1;
    localparam int unsigned IDX_W       = ACT_IDX_HI - ACT_IDX_LO + 1;
    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned CONT_W      = 16;
    localparam int unsigned NUM_CONT_2B = 8;
    localparam int unsigned SEG_2B_W    = CONT_W * NUM_CONT_2B;

    localparam logic [1:0] TYPE_2B = 2'd1;
    localparam logic [1:0] TYPE_4B = 2'd2;
    localparam logic [1:0] TYPE_8B = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } parse_state_e;

endpackage

// File: rtl/sub_parser_act_decode.sv
// Combinational decode of one parse action into bank read addresses and target
// container; TYPE_CODE selects which action type this sub-parser services.
module sub_parser_act_decode
    import parser_pkg::*;
#(
    parameter logic [1:0] TYPE_CODE = TYPE_2B
) (
    input  logic [ACT_LEN-1:0] act,
    output logic               serviced_c,
    output logic [OFF_W-1:0]   off_c,
    output logic [ADDR_W-1:0]  addr_even_c,
    output logic [ADDR_W-1:0]  addr_odd_c,
    output logic               odd_c,
    output logic [IDX_W-1:0]   k_c
);

    // Bits between valid and offset are reserved and carry no meaning here.
    logic unused_rsvd;
    assign unused_rsvd = ^act[ACT_VALID_BIT-1:ACT_OFF_HI+1];

    // Odd start fetches the low byte from the odd bank, so the even bank moves one word up.
    always_comb begin
        serviced_c  = act[ACT_VALID_BIT] && (act[ACT_TYPE_HI:ACT_TYPE_LO] == TYPE_CODE);
        off_c       = act[ACT_OFF_HI:ACT_OFF_LO];
        odd_c       = act[ACT_ODD_BIT];
        k_c         = act[ACT_IDX_HI:ACT_IDX_LO];
        addr_odd_c  = ADDR_W'(off_c);
        addr_even_c = ADDR_W'(off_c) + ADDR_W'(odd_c);
    end

endmodule

// File: rtl/sub_parser_2b_extract.sv
// Walks the parse-action list, reads the even/odd header banks and assembles the
// eight 16-bit PHV 2B containers. Optional duplicate-index check: SUB_PARSER_2B_DUP_CHK_EN.
module sub_parser_2b_extract
    import parser_pkg::*;
#(
    parameter int unsigned C_PARSE_ACT_LEN = 16,
    parameter int unsigned C_NUM_ACTS      = 10
) (
    input  logic                                  clk,
    input  logic                                  aresetn,
    input  logic                                  parse_act_srt,
    input  logic [C_NUM_ACTS*C_PARSE_ACT_LEN-1:0] parse_acts,
    output logic                                  o_ready,
    output logic                                  ram_rd_en,
    output logic [7:0]                            ram_rd_addr_even,
    output logic [7:0]                            ram_rd_addr_odd,
    input  logic [7:0]                            ram_rd_data_even,
    input  logic [7:0]                            ram_rd_data_odd,
    output logic [127:0]                          o_2B_val,
    output logic                                  o_val_valid,
    output logic                                  o_dup_err
);

    localparam int unsigned ACTS_W   = C_NUM_ACTS * C_PARSE_ACT_LEN;
    localparam int unsigned CNT_W    = (C_NUM_ACTS > 1) ? $clog2(C_NUM_ACTS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(C_NUM_ACTS - 1);

    parse_state_e         state_q, state_d;
    logic [CNT_W-1:0]     idx_q, idx_d;
    logic [ACTS_W-1:0]    acts_q, acts_d;
    logic                 rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]    addr_even_q, addr_even_d;
    logic [ADDR_W-1:0]    addr_odd_q, addr_odd_d;
    logic [IDX_W-1:0]     iss_k_q, iss_k_d;
    logic                 iss_odd_q, iss_odd_d;
    logic                 cap_vld_q, cap_vld_d;
    logic [IDX_W-1:0]     cap_k_q, cap_k_d;
    logic                 cap_odd_q, cap_odd_d;
    logic [SEG_2B_W-1:0]  val_q, val_d;
    logic                 val_valid_q, val_valid_d;
    logic                 ready_q, ready_d;

    logic [C_PARSE_ACT_LEN-1:0] act_sel;
    logic                       dec_svc;
    logic [OFF_W-1:0]           dec_off_unused;
    logic [ADDR_W-1:0]          dec_addr_even;
    logic [ADDR_W-1:0]          dec_addr_odd;
    logic                       dec_odd;
    logic [IDX_W-1:0]           dec_k;

`ifdef SUB_PARSER_2B_DUP_CHK_EN
    logic [NUM_CONT_2B-1:0] mask_q, mask_d;
    logic                   dup_seen_q, dup_seen_d;
    logic                   dup_err_q, dup_err_d;
`endif

    // Outputs are registered, so the action decoded now is the one issued next cycle:
    // action 0 straight from the input at start, then slot 1 of the shifting copy.
    assign act_sel = (state_q == ST_IDLE) ? parse_acts[C_PARSE_ACT_LEN-1:0]
                                          : acts_q[2*C_PARSE_ACT_LEN-1 -: C_PARSE_ACT_LEN];

    sub_parser_act_decode #(
        .TYPE_CODE (TYPE_2B)
    ) u_act_decode (
        .act         (act_sel),
        .serviced_c  (dec_svc),
        .off_c       (dec_off_unused),
        .addr_even_c (dec_addr_even),
        .addr_odd_c  (dec_addr_odd),
        .odd_c       (dec_odd),
        .k_c         (dec_k)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acts_d      = acts_q;
        rd_en_d     = 1'b0;
        addr_even_d = addr_even_q;
        addr_odd_d  = addr_odd_q;
        iss_k_d     = iss_k_q;
        iss_odd_d   = iss_odd_q;
        cap_vld_d   = rd_en_q;
        cap_k_d     = iss_k_q;
        cap_odd_d   = iss_odd_q;
        val_d       = val_q;
        val_valid_d = 1'b0;
`ifdef SUB_PARSER_2B_DUP_CHK_EN
        mask_d      = mask_q;
        dup_seen_d  = dup_seen_q;
        dup_err_d   = dup_err_q;
`endif

        // Capture the bank data returned for the action issued last cycle.
        if (cap_vld_q) begin
            if (cap_odd_q) begin
                val_d[{cap_k_q, 4'd0} +: BYTE_W] = ram_rd_data_odd;
                val_d[{cap_k_q, 4'd8} +: BYTE_W] = ram_rd_data_even;
            end else begin
                val_d[{cap_k_q, 4'd0} +: BYTE_W] = ram_rd_data_even;
                val_d[{cap_k_q, 4'd8} +: BYTE_W] = ram_rd_data_odd;
            end
`ifdef SUB_PARSER_2B_DUP_CHK_EN
            if (mask_q[cap_k_q]) begin
                dup_seen_d = 1'b1;
            end
            mask_d[cap_k_q] = 1'b1;
`endif
        end

        case (state_q)
            ST_IDLE: begin
                if (parse_act_srt) begin
                    state_d = ST_ISSUE;
                    idx_d   = '0;
                    acts_d  = parse_acts;
                    val_d   = '0;
                    rd_en_d = dec_svc;
`ifdef SUB_PARSER_2B_DUP_CHK_EN
                    mask_d     = '0;
                    dup_seen_d = 1'b0;
                    dup_err_d  = 1'b0;
`endif
                end
            end
            ST_ISSUE: begin
                acts_d = acts_q >> C_PARSE_ACT_LEN;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                end else begin
                    idx_d   = idx_q + CNT_W'(1);
                    rd_en_d = dec_svc;
                end
            end
            ST_DRAIN: begin
                state_d     = ST_DONE;
                val_valid_d = 1'b1;
`ifdef SUB_PARSER_2B_DUP_CHK_EN
                dup_err_d   = dup_seen_d;
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Skipped slots leave the address lines and pipeline tags untouched.
        if (rd_en_d) begin
            addr_even_d = dec_addr_even;
            addr_odd_d  = dec_addr_odd;
            iss_k_d     = dec_k;
            iss_odd_d   = dec_odd;
        end

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            acts_q      <= '0;
            rd_en_q     <= 1'b0;
            addr_even_q <= '0;
            addr_odd_q  <= '0;
            iss_k_q     <= '0;
            iss_odd_q   <= 1'b0;
            cap_vld_q   <= 1'b0;
            cap_k_q     <= '0;
            cap_odd_q   <= 1'b0;
            val_q       <= '0;
            val_valid_q <= 1'b0;
            ready_q     <= 1'b1;
`ifdef SUB_PARSER_2B_DUP_CHK_EN
            mask_q      <= '0;
            dup_seen_q  <= 1'b0;
            dup_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acts_q      <= acts_d;
            rd_en_q     <= rd_en_d;
            addr_even_q <= addr_even_d;
            addr_odd_q  <= addr_odd_d;
            iss_k_q     <= iss_k_d;
            iss_odd_q   <= iss_odd_d;
            cap_vld_q   <= cap_vld_d;
            cap_k_q     <= cap_k_d;
            cap_odd_q   <= cap_odd_d;
            val_q       <= val_d;
            val_valid_q <= val_valid_d;
            ready_q     <= ready_d;
`ifdef SUB_PARSER_2B_DUP_CHK_EN
            mask_q      <= mask_d;
            dup_seen_q  <= dup_seen_d;
            dup_err_q   <= dup_err_d;
`endif
        end
    end

    assign o_ready          = ready_q;
    assign ram_rd_en        = rd_en_q;
    assign ram_rd_addr_even = addr_even_q;
    assign ram_rd_addr_odd  = addr_odd_q;
    assign o_2B_val         = val_q;
    assign o_val_valid      = val_valid_q;
`ifdef SUB_PARSER_2B_DUP_CHK_EN
    assign o_dup_err        = dup_err_q;
`else
    assign o_dup_err        = 1'b0;
`endif

endmodule

// File: doc/sub_parser_2b_extract.md
# sub_parser_2b_extract

Packet-side counterpart of the 2-byte sub-deparser. It walks a packed list of parse actions and issues reads to the even/odd byte banks of the packet header RAM. From the returned bytes it assembles the eight 16-bit containers of the PHV 2B segment (`o_2B_val`). It sits in the parser stage ahead of the match-action pipeline and uses the same parse-action encoding and even/odd bank layout that the deparser writes.

## Interface
- `C_PARSE_ACT_LEN`, default 16: width of one parse action.
- `C_NUM_ACTS`, default 10: number of actions in `parse_acts`.
- `clk`  in  1: clock.
- `aresetn`  in  1: reset, synchronous, active-low.
- `parse_act_srt`  in  1: one-cycle start pulse; sampled only while `o_ready`=1.
- `parse_acts`  in  `C_NUM_ACTS*C_PARSE_ACT_LEN`: action i at bits `[i*16 +: 16]`; action 0 is processed first.
- `o_ready`  out  1: idle, can accept a start pulse.
- `ram_rd_en`  out  1: read strobe for both banks.
- `ram_rd_addr_even`  out  8: even-bank byte address.
- `ram_rd_addr_odd`  out  8: odd-bank byte address.
- `ram_rd_data_even`  in  8: even-bank data, valid 1 cycle after `ram_rd_en`.
- `ram_rd_data_odd`  in  8: odd-bank data, valid 1 cycle after `ram_rd_en`.
- `o_2B_val`  out  128: container k at bits `[16k +: 16]`.
- `o_val_valid`  out  1: one-cycle pulse; `o_2B_val` is complete.
- `o_dup_err`  out  1: duplicate-index flag, qualified by `o_val_valid` (see Configuration).

## Operation
- Action fields:
  - `[15]` valid.
  - `[12:6]` word offset (off).
  - `[5]` odd start byte.
  - `[4:2]` container index k.
  - `[1:0]` type; `2'b01` = 2B.
- An action is serviced only if `[15]`=1 and `[1:0]`=`2'b01`. All other actions are skipped, but each still occupies its issue slot: `ram_rd_en`=0 and no write.
- Addressing, `[5]`=0:
  - even addr = off, odd addr = off.
  - byte 2k ← even data; byte 2k+1 ← odd data.
- Addressing, `[5]`=1:
  - even addr = off+1, computed 8-bit (off=127 gives 128, no wrap); odd addr = off.
  - byte 2k ← odd data; byte 2k+1 ← even data.
- Byte 2k is `o_2B_val[16k +: 8]`; byte 2k+1 is `o_2B_val[16k+8 +: 8]`.
- FSM:
  - IDLE: `o_ready`=1. On `parse_act_srt`, latch `parse_acts`, clear `o_2B_val` and the dup mask, set index i=0, go to ISSUE.
  - ISSUE: issue action i. If i=`C_NUM_ACTS`-1 go to DRAIN, else increment i.
  - DRAIN: capture the last read; go to DONE.
  - DONE: pulse `o_val_valid`; go to IDLE.
- A one-deep pipeline register carries k, `[5]` and the serviced bit from the issue cycle to the capture cycle.
- Containers with no serviced action read 0.
- Two actions with the same k: the later action wins.
- `parse_act_srt` while `o_ready`=0 is ignored.
- Reset mid-operation: return to IDLE next edge, drop in-flight reads, apply reset values.

## Timing
- Reset values: `o_ready`=1, `ram_rd_en`=0, addresses=0, `o_2B_val`=0, `o_val_valid`=0, `o_dup_err`=0.
- Start accepted at edge 0. Action i is issued in cycle 1+i and written to `o_2B_val` at edge 2+i.
- `o_val_valid` is high in cycle `C_NUM_ACTS`+2 (cycle 12 with defaults).
- `o_ready` returns high the cycle after `o_val_valid`, so back-to-back jobs start every `C_NUM_ACTS`+3 cycles.
- `o_2B_val` holds its value until the next accepted start.
- The RAM read latency is fixed at 1 cycle; this block does not support other latencies.

## Configuration
- `SUB_PARSER_2B_DUP_CHK_EN` defined:
  - Keep an 8-bit written mask.
  - A serviced action whose k bit is already set makes `o_dup_err` go 1 together with `o_val_valid`.
  - `o_dup_err` clears on the next accepted start.
- Not defined: `o_dup_err` is constant 0 and no mask logic is built.

## Structure
- Shared package `parser_pkg` holds:
  - action field positions (`ACT_VALID_BIT`, `ACT_OFF_HI/LO`, `ACT_ODD_BIT`, `ACT_IDX_HI/LO`, `ACT_TYPE_HI/LO`);
  - type codes (`TYPE_2B`=1, `TYPE_4B`=2, `TYPE_8B`=3);
  - the FSM state enum.
- One sub-module, `sub_parser_act_decode`: combinational decode of one action into serviced, off, even/odd addresses, odd flag and k. It is reusable by the 4B/8B sub-parsers.

## Test plan
- Action 0 = `16'h8045`, i.e. valid, off=1, even start, k=1, 2B. Even[1]=`8'hAA`, odd[1]=`8'hBB`. Required: `o_2B_val[31:16]`=`16'hBBAA`, all other containers 0, `o_val_valid` in cycle 12.
- Odd-start action `16'h80E1`, i.e. off=3, odd start, k=0. Required: `ram_rd_addr_even`=4, `ram_rd_addr_odd`=3. With odd[3]=`8'h11`, even[4]=`8'h22`: `o_2B_val[15:0]`=`16'h2211`.
- Action with off=127 and odd start. Required: `ram_rd_addr_even`=128, `ram_rd_addr_odd`=127.
- Mixed list: invalid actions, 4B-type actions, and two actions with k=5. Required: skipped slots keep `ram_rd_en`=0, the later k=5 data wins, and with `SUB_PARSER_2B_DUP_CHK_EN` defined `o_dup_err`=1.
- Start pulse during ISSUE is ignored. Reset asserted during ISSUE: all outputs return to reset values and `o_val_valid` never pulses. A fresh job after reset completes correctly.
- Back-to-back jobs: the second start lands in the cycle `o_ready` rises. Required: the second job's `o_val_valid` pulses exactly 13 cycles after the first.
